// File: rtl/dm.sv
// Data memory for the single-cycle MIPS datapath: word RAM, sub-word stores, extended combinational loads.
// Optional store log enabled by defining DM_WRITE_LOG_EN.
module dm #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [1:0]  st_type,
  input  logic [2:0]  ld_type,
  output logic [31:0] rdata,
  output logic        align_err
);

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   wmerge;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          st_err;
  logic          ld_err;
  logic          commit;
  logic          unused_bits;

  assign idx   = addr[AW+1:2];
  assign rword = mem[idx];
  assign rbyte = rword[{addr[1:0], 3'b000} +: 8];
  assign rhalf = addr[1] ? rword[31:16] : rword[15:0];

  // pc only feeds the optional log; high address bits wrap away.
  assign unused_bits = ^{pc, addr[31:AW+2]};

  always_comb begin
    st_err = 1'b0;
    case (st_type)
      2'b00:   st_err = (addr[1:0] != 2'b00);
      2'b01:   st_err = addr[0];
      default: st_err = 1'b0;
    endcase
  end

  always_comb begin
    ld_err = 1'b0;
    case (ld_type)
      3'b000:        ld_err = (addr[1:0] != 2'b00);
      3'b001, 3'b010: ld_err = addr[0];
      default:       ld_err = 1'b0;
    endcase
  end

  assign align_err = mem_write ? st_err : ld_err;
  assign commit    = mem_write && !st_err && (st_type != 2'b11);

  always_comb begin
    rdata = 32'h0;
    if (!ld_err) begin
      case (ld_type)
        3'b000:  rdata = rword;
        3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
        3'b010:  rdata = {16'h0, rhalf};
        3'b011:  rdata = {{24{rbyte[7]}}, rbyte};
        3'b100:  rdata = {24'h0, rbyte};
        default: rdata = 32'h0;
      endcase
    end
  end

  // Merge store data into the current word so untouched lanes survive.
  always_comb begin
    wmerge = rword;
    case (st_type)
      2'b00: wmerge = wdata;
      2'b01: begin
        if (addr[1]) wmerge[31:16] = wdata[15:0];
        else         wmerge[15:0]  = wdata[15:0];
      end
      2'b10:   wmerge[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      default: wmerge = rword;
    endcase
  end

`ifdef DM_WRITE_LOG_EN
  function automatic string hex8(input logic [31:0] v);
    string s;
    logic [3:0] n;
    s = "";
    for (int i = 7; i >= 0; i--) begin
      n = v[i*4 +: 4];
      s = $sformatf("%s%c", s, (n < 4'd10) ? (8'd48 + {4'd0, n}) : (8'd55 + {4'd0, n}));
    end
    return s;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
    end else if (commit) begin
      mem[idx] <= wmerge;
`ifdef DM_WRITE_LOG_EN
      $display("@%s: *%s <= %s", hex8(pc), hex8({addr[31:2], 2'b00}), hex8(wmerge));
`else
`endif
    end
  end

endmodule

// File: tb/tb_dm.sv
// Randomised and directed bench for dm against a byte-addressed reference memory.
module tb_dm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_write = 1'b0;
  logic [1:0]  st_type = 2'b00;
  logic [2:0]  ld_type = 3'b000;
  logic [31:0] rdata;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  // 4 KiB byte image; address bits above 11 wrap away.
  logic [7:0] bm [4096];

  dm #(.WORDS(1024), .AW(10)) u_dm (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .st_type(st_type), .ld_type(ld_type),
    .rdata(rdata), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_align(input logic mw, input logic [1:0] st,
                                     input logic [2:0] ld, input logic [31:0] a);
    if (mw) return (st == 2'd0) ? (a[1:0] != 0) : (st == 2'd1) ? a[0] : 1'b0;
    if (ld == 3'd0) return a[1:0] != 0;
    if (ld == 3'd1 || ld == 3'd2) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] ld, input logic [31:0] a);
    int b;
    logic [15:0] h;
    b = int'(a[11:0]);
    h = {bm[(b & ~1) + 1], bm[b & ~1]};
    case (ld)
      3'd0: return (a[1:0] != 0) ? 32'h0 :
                   {bm[b + 3], bm[b + 2], bm[b + 1], bm[b]};
      3'd1: return a[0] ? 32'h0 : 32'(signed'(h));
      3'd2: return a[0] ? 32'h0 : {16'h0, h};
      3'd3: return 32'(signed'(bm[b]));
      3'd4: return {24'h0, bm[b]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_store(input logic [1:0] st, input logic [31:0] a,
                                      input logic [31:0] wd);
    int b;
    b = int'(a[11:0]);
    case (st)
      2'd0: for (int k = 0; k < 4; k++) bm[b + k] = wd[k*8 +: 8];
      2'd1: begin bm[b] = wd[7:0]; bm[b + 1] = wd[15:8]; end
      2'd2: bm[b] = wd[7:0];
      default: ;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4096; i++) bm[i] = 8'h0;
  endfunction

  // One cycle: drive just after a rising edge, check mid-cycle, commit at next edge.
  task automatic do_op(input logic rst, input logic mw, input logic [1:0] st,
                       input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pcv);
    logic ea;
    reset = rst; mem_write = mw; st_type = st; ld_type = ld;
    addr = a; wdata = wd; pc = pcv;
    #4;
    ea = exp_align(mw, st, ld, a);
    check("align_err", {31'h0, align_err}, {31'h0, ea});
    check("rdata", rdata, exp_load(ld, a));
    @(posedge clk);
    if (rst) model_clear();
    else if (mw && !ea) model_store(st, a, wd);
    #1;
    mem_write = 1'b0; reset = 1'b0;
  endtask

  task automatic expect_load(input string tag, input logic [2:0] ld,
                             input logic [31:0] a, input logic [31:0] exp);
    mem_write = 1'b0; reset = 1'b0; ld_type = ld; addr = a;
    #4;
    check(tag, rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    expect_load("reset_lw0", 3'd0, 32'h0, 32'h0);
    expect_load("reset_lw3fc", 3'd0, 32'h3FC, 32'h0);

    do_op(0, 1, 2'd0, 3'd0, 32'h14, 32'hDEADBEEF, 32'h0);
    expect_load("preload", 3'd0, 32'h14, 32'hDEADBEEF);
    do_op(1, 0, 2'd0, 3'd0, 32'h14, 32'h0, 32'h0);
    expect_load("reset_clear", 3'd0, 32'h14, 32'h0);

    do_op(0, 1, 2'd0, 3'd0, 32'h20, 32'h11223344, 32'h0);
    do_op(0, 1, 2'd2, 3'd0, 32'h22, 32'h000000AA, 32'h0);
    do_op(0, 1, 2'd1, 3'd0, 32'h20, 32'h0000BEEF, 32'h0);
    expect_load("merge", 3'd0, 32'h20, 32'h11AABEEF);

    do_op(0, 1, 2'd0, 3'd0, 32'h40, 32'h80FF7F01, 32'h0);
    expect_load("lb43", 3'd3, 32'h43, 32'hFFFFFF80);
    expect_load("lbu43", 3'd4, 32'h43, 32'h00000080);
    expect_load("lh40", 3'd1, 32'h40, 32'h00007F01);
    expect_load("lhu42", 3'd2, 32'h42, 32'h000080FF);
    expect_load("lh42", 3'd1, 32'h42, 32'hFFFF80FF);

    do_op(0, 1, 2'd0, 3'd0, 32'h21, 32'h55555555, 32'h0);
    expect_load("sw_misalign_nochg", 3'd0, 32'h20, 32'h11AABEEF);
    do_op(0, 0, 2'd0, 3'd1, 32'h23, 32'h0, 32'h0);
    do_op(0, 1, 2'd3, 3'd0, 32'h20, 32'hFFFFFFFF, 32'h0);
    expect_load("reserved_nochg", 3'd0, 32'h20, 32'h11AABEEF);

    do_op(0, 1, 2'd0, 3'd0, 32'h1000, 32'h12345678, 32'h0);
    expect_load("wrap", 3'd0, 32'h0, 32'h12345678);

    do_op(0, 1, 2'd0, 3'd0, 32'h8, 32'hCAFEF00D, 32'h0);
    mem_write = 1'b1; st_type = 2'd0; ld_type = 3'd0; addr = 32'h8; wdata = 32'h01020304;
    #4;
    check("rdw_old", rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    model_store(2'd0, 32'h8, 32'h01020304);
    expect_load("rdw_new", 3'd0, 32'h8, 32'h01020304);

    do_op(0, 1, 2'd0, 3'd0, 32'h30, 32'h0, 32'h0);
    do_op(0, 1, 2'd2, 3'd0, 32'h30, 32'h000000A1, 32'h0);
    do_op(0, 1, 2'd2, 3'd0, 32'h31, 32'h000000B2, 32'h0);
    expect_load("b2b_bytes", 3'd0, 32'h30, 32'h0000B2A1);

    do_op(1, 1, 2'd0, 3'd0, 32'h30, 32'hFFFFFFFF, 32'h0);
    expect_load("reset_drops_store", 3'd0, 32'h30, 32'h0);

    do_op(0, 1, 2'd0, 3'd0, 32'h20, 32'h11223344, 32'h0);
    do_op(0, 1, 2'd2, 3'd0, 32'h22, 32'h000000AA, 32'h00003010);
    expect_load("log_word", 3'd0, 32'h20, 32'h11AA3344);

    for (int n = 0; n < 1500; n++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[11:5] = 7'h0;
      do_op($urandom_range(99) == 0, $urandom_range(1) == 1, 2'($urandom_range(3)),
            3'($urandom_range(5)), a, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm.md
# dm

Data memory for the single-cycle MIPS datapath, directly downstream of the ALU. The ALU result drives `addr`, and the rt register value drives `wdata`. The block holds a word-organised RAM with sub-word stores (sw/sh/sb) and sign- or zero-extended loads (lw/lh/lhu/lb/lbu). Its read result feeds the register-file write-back mux.

## Interface
- `WORDS`, default 1024: number of 32-bit words (4 KiB). Must be a power of two.
- `AW`, default 10: word-index width, equal to log2(`WORDS`).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; clears the whole array.
- `pc` input 32: PC of the instruction in flight; used only for the write log.
- `addr` input 32: byte address, taken from the ALU result.
- `wdata` input 32: store data; the low byte or low half is used for sb and sh.
- `mem_write` input 1: store enable.
- `st_type` input 2: 00 sw, 01 sh, 10 sb, 11 reserved (treated as no store).
- `ld_type` input 3: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others return 0.
- `rdata` output 32: extended load result.
- `align_err` output 1: the current access is misaligned for its type.

## Operation
- Word index is `addr[AW+1:2]`. Bits above `AW+1` are ignored, so addresses wrap modulo 4·`WORDS`.
- Byte lane is `addr[1:0]`, little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- Half lane is `addr[1]`: 0 selects bits 15:0, 1 selects bits 31:16.
- Alignment rules:
  - sw/lw require `addr[1:0]==0`.
  - sh/lh/lhu require `addr[0]==0`.
  - Byte accesses are always aligned.
- `align_err` is combinational:
  - When `mem_write`=1, it is evaluated against `st_type`.
  - When `mem_write`=0, it is evaluated against `ld_type`.
- Store behaviour:
  - sw replaces the whole word.
  - sh replaces only the selected half with `wdata[15:0]`.
  - sb replaces only the selected byte with `wdata[7:0]`.
  - The other lanes of the word are preserved.
- A store is suppressed entirely, leaving the array unchanged, when any of these hold: `align_err`=1, `st_type`=11, or `reset`=1.
- Load behaviour:
  - lh and lb sign-extend from bit 15 and bit 7 respectively.
  - lhu and lbu zero-extend.
- A misaligned load returns 0 and asserts `align_err`.
- Reset clears every word to 0 on the edge where `reset`=1, independent of `mem_write`.
- No state machine; the only state is the RAM array.

## Timing
- Loads are combinational: `rdata` reflects the array contents and the current `addr`/`ld_type` in the same cycle.
- Stores commit on the rising edge of `clk`.
- Read-during-write to the same word returns the old contents in that cycle; the new value is visible from the next cycle.
- Back-to-back stores to the same word in consecutive cycles accumulate. Example: sb lane 0, then sb lane 1, yields both bytes updated.
- Reset values:
  - All words are 0.
  - `rdata` is 0 for every in-range aligned load after reset.
  - `align_err` is purely combinational and has no reset value.
- Reset asserted mid-sequence discards any store presented in that cycle. Stores resume on the first edge with `reset`=0.

## Configuration
- Macro: `DM_WRITE_LOG_EN`.
- When defined, every committed store issues one `$display` at the commit edge, in the form `@<pc hex 8>: *<word-aligned addr hex 8> <= <full resulting word hex 8>`.
  - The address is `{addr[31:2],2'b00}`.
  - The data is the merged word after the sub-word update.
  - Suppressed stores print nothing.
- When not defined, no log output is produced. RTL behaviour is otherwise identical.

## Test plan
- **Reset clear:** preload word 5 with 32'hDEADBEEF, assert `reset` for one cycle -> lw from 0x14 returns 0.
- **Sub-word store merge:** sw 32'h11223344 to 0x20, then sb `wdata`=0xAA to 0x22, then sh `wdata`=0xBEEF to 0x20 -> lw 0x20 returns 32'h11AABEEF.
- **Load extension:** with word 0x40 = 32'h80FF7F01:
  - lb 0x43 -> 32'hFFFFFF80.
  - lbu 0x43 -> 32'h00000080.
  - lh 0x40 -> 32'h00007F01.
  - lhu 0x42 -> 32'h000080FF.
  - lh 0x42 -> 32'hFFFF80FF.
- **Misalignment:**
  - sw to 0x21 -> `align_err`=1, word 0x20 unchanged.
  - lh from 0x23 -> `rdata`=0 and `align_err`=1.
- **Wrap-around and read-during-write:**
  - sw 32'h12345678 to 0x1000 with `WORDS`=1024 -> lw 0x0 returns 32'h12345678.
  - In the same cycle as a store to 0x8, lw 0x8 shows the old value, and shows the new value next cycle.
- **Log (with `DM_WRITE_LOG_EN`):** sb 0xAA to 0x22 with `pc`=32'h00003010 over word 32'h11223344 -> exactly one line, `@00003010: *00000020 <= 11AA3344`.
